// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: a registered-state FSM that sequences
// fetch, decode, memory, ALU, branch and jump steps and drives datapath selects.
module multicycle_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       f7_5,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       PC_WRITE,
  output logic       ADR_SRC,
  output logic       MEM_WRITE,
  output logic       IR_WRITE,
  output logic       REG_WRITE,
  output logic [1:0] RES_SRC,
  output logic [1:0] ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] IMM_SRC,
  output logic [3:0] ALU_CONTROL,
  output logic       ILLEGAL,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  state_t     state_q;
  state_t     state_d;
  logic       illegal_q;
  logic       pc_w;
  logic       mem_w;
  logic       ir_w;
  logic       reg_w;
  logic [3:0] alu_dec;

  // State and sticky illegal flag; the flag rises together with TRAP entry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP)
        illegal_q <= 1'b1;
    end
  end

  // ALU operation for R/I-type; op[5] separates register SUB from ADDI.
  always_comb begin
    alu_dec = ALU_ADD;
    unique case (f3)
      3'b000: alu_dec = (op[5] && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_dec = ALU_SLL;
      3'b010: alu_dec = ALU_SLT;
      3'b011: alu_dec = ALU_SLTU;
      3'b100: alu_dec = ALU_XOR;
      3'b101: alu_dec = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_dec = ALU_OR;
      3'b111: alu_dec = ALU_AND;
    endcase
  end

  // Next state and per-state datapath controls; everything unlisted stays 0.
  always_comb begin
    state_d     = state_q;
    pc_w        = 1'b0;
    mem_w       = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    ADR_SRC     = 1'b0;
    RES_SRC     = 2'b00;
    ALU_SRC_A   = 2'b00;
    ALU_SRC_B   = 2'b00;
    IMM_SRC     = 3'b000;
    ALU_CONTROL = ALU_ADD;
    case (state_q)
      FETCH: begin
        ALU_SRC_B = 2'b10;
        RES_SRC   = 2'b10;
        if (MEM_READY) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b01;
        IMM_SRC   = 3'b010;
        case (op)
          7'b0000011: state_d = MEMADR;
          7'b0100011: state_d = MEMADR;
          7'b0110011: state_d = EXECR;
          7'b0010011: state_d = EXECI;
          7'b1100011: state_d = BRANCH;
          7'b1101111: state_d = JAL;
          7'b1100111: state_d = JALR;
          7'b0110111: state_d = LUI;
          default:    state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ALU_SRC_A = 2'b10;
        ALU_SRC_B = 2'b01;
        IMM_SRC   = op[5] ? 3'b001 : 3'b000;
        state_d   = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        ADR_SRC = 1'b1;
        if (MEM_READY)
          state_d = MEMWB;
      end
      MEMWB: begin
        RES_SRC = 2'b01;
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        ADR_SRC = 1'b1;
        mem_w   = 1'b1;
        if (MEM_READY)
          state_d = FETCH;
      end
      EXECR: begin
        ALU_SRC_A   = 2'b10;
        ALU_CONTROL = alu_dec;
        state_d     = ALUWB;
      end
      EXECI: begin
        ALU_SRC_A   = 2'b10;
        ALU_SRC_B   = 2'b01;
        ALU_CONTROL = alu_dec;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALU_SRC_A   = 2'b10;
        ALU_CONTROL = ALU_SUB;
        state_d     = FETCH;
        if (f3 == 3'b000)
          pc_w = ZERO;
        else if (f3 == 3'b001)
          pc_w = !ZERO;
        else
          state_d = TRAP;
      end
      JAL: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b10;
        pc_w      = 1'b1;
        state_d   = ALUWB;
      end
      JALR: begin
        ALU_SRC_A = 2'b10;
        ALU_SRC_B = 2'b01;
        RES_SRC   = 2'b10;
        pc_w      = 1'b1;
        state_d   = JAL;
      end
      LUI: begin
        ALU_SRC_A = 2'b10;
        ALU_SRC_B = 2'b01;
        IMM_SRC   = 3'b100;
        state_d   = ALUWB;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign PC_WRITE  = pc_w  & ~RESET;
  assign MEM_WRITE = mem_w & ~RESET;
  assign IR_WRITE  = ir_w  & ~RESET;
  assign REG_WRITE = reg_w & ~RESET;
  assign ILLEGAL   = illegal_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle input records
// with hand-computed packed expected outputs, plus a trap sequence.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7_5;
  logic       ZERO;
  logic       MEM_READY;
  logic       PC_WRITE;
  logic       ADR_SRC;
  logic       MEM_WRITE;
  logic       IR_WRITE;
  logic       REG_WRITE;
  logic [1:0] RES_SRC;
  logic [1:0] ALU_SRC_A;
  logic [1:0] ALU_SRC_B;
  logic [2:0] IMM_SRC;
  logic [3:0] ALU_CONTROL;
  logic       ILLEGAL;
  logic [3:0] STATE;

  multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .op(op), .f3(f3), .f7_5(f7_5),
    .ZERO(ZERO), .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE),
    .ADR_SRC(ADR_SRC), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
    .REG_WRITE(REG_WRITE), .RES_SRC(RES_SRC), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .IMM_SRC(IMM_SRC), .ALU_CONTROL(ALU_CONTROL),
    .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic        z;
    logic        mr;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  logic [22:0] act;
  assign act = {PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE,
                RES_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC, ALU_CONTROL,
                ILLEGAL, STATE};

  localparam logic [6:0] O_LD  = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011;
  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_JR  = 7'b1100111;
  localparam logic [6:0] O_LUI = 7'b0110111;

  // pack: pcw adr mw irw rw res a b imm alu ill state
  function automatic logic [22:0] ex(
    input logic pcw, input logic adr, input logic mw,
    input logic irw, input logic rw, input logic [1:0] res,
    input logic [1:0] a, input logic [1:0] b, input logic [2:0] imm,
    input logic [3:0] alu, input logic ill, input logic [3:0] st);
    return {pcw, adr, mw, irw, rw, res, a, b, imm, alu, ill, st};
  endfunction

  task automatic add(input logic rst, input logic [6:0] o,
                     input logic [2:0] f, input logic f7,
                     input logic z, input logic mr,
                     input logic [22:0] e);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f; v.f75 = f7;
    v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic drive(input logic rst, input logic [6:0] o,
                       input logic [2:0] f, input logic f7,
                       input logic z, input logic mr);
    RESET = rst; op = o; f3 = f; f7_5 = f7; ZERO = z; MEM_READY = mr;
    #1;
  endtask

  logic [22:0] f0, f1, dc, awb;

  initial begin
    f0  = ex(0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,4'd0,0,4'd0);
    f1  = ex(1,0,0,1,0,2'd2,2'd0,2'd2,3'd0,4'd0,0,4'd0);
    dc  = ex(0,0,0,0,0,2'd0,2'd1,2'd1,3'd2,4'd0,0,4'd1);
    awb = ex(0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,4'd0,0,4'd8);

    // reset holds strobes low even with MEM_READY=1
    add(1, O_I, 0, 0, 0, 1, f0);
    // ADDI
    add(0, O_I, 0, 0, 0, 1, f1);
    add(0, O_I, 0, 0, 0, 1, dc);
    add(0, O_I, 0, 0, 0, 1, ex(0,0,0,0,0,0,2,1,0,4'd0,0,4'd7));
    add(0, O_I, 0, 0, 0, 1, awb);
    // LW with a fetch stall and 3 read stalls
    add(0, O_LD, 2, 0, 0, 0, f0);
    add(0, O_LD, 2, 0, 0, 1, f1);
    add(0, O_LD, 2, 0, 0, 1, dc);
    add(0, O_LD, 2, 0, 0, 1, ex(0,0,0,0,0,0,2,1,0,4'd0,0,4'd2));
    for (int i = 0; i < 3; i++)
      add(0, O_LD, 2, 0, 0, 0, ex(0,1,0,0,0,0,0,0,0,4'd0,0,4'd3));
    add(0, O_LD, 2, 0, 0, 1, ex(0,1,0,0,0,0,0,0,0,4'd0,0,4'd3));
    add(0, O_LD, 2, 0, 0, 1, ex(0,0,0,0,1,1,0,0,0,4'd0,0,4'd4));
    // SW with 2 write stalls
    add(0, O_ST, 2, 0, 0, 1, f1);
    add(0, O_ST, 2, 0, 0, 1, dc);
    add(0, O_ST, 2, 0, 0, 1, ex(0,0,0,0,0,0,2,1,1,4'd0,0,4'd2));
    add(0, O_ST, 2, 0, 0, 0, ex(0,1,1,0,0,0,0,0,0,4'd0,0,4'd5));
    add(0, O_ST, 2, 0, 0, 0, ex(0,1,1,0,0,0,0,0,0,4'd0,0,4'd5));
    add(0, O_ST, 2, 0, 0, 1, ex(0,1,1,0,0,0,0,0,0,4'd0,0,4'd5));
    // BEQ not taken, BNE taken, BEQ taken
    add(0, O_BR, 0, 0, 0, 1, f1);
    add(0, O_BR, 0, 0, 0, 1, dc);
    add(0, O_BR, 0, 0, 0, 1, ex(0,0,0,0,0,0,2,0,0,4'd1,0,4'd9));
    add(0, O_BR, 1, 0, 0, 1, f1);
    add(0, O_BR, 1, 0, 0, 1, dc);
    add(0, O_BR, 1, 0, 0, 1, ex(1,0,0,0,0,0,2,0,0,4'd1,0,4'd9));
    add(0, O_BR, 0, 0, 1, 1, f1);
    add(0, O_BR, 0, 0, 1, 1, dc);
    add(0, O_BR, 0, 0, 1, 1, ex(1,0,0,0,0,0,2,0,0,4'd1,0,4'd9));
    // SUB, SRL (R-type), SRAI, ADDI with f7_5=1 stays ADD
    add(0, O_R, 0, 1, 0, 1, f1);
    add(0, O_R, 0, 1, 0, 1, dc);
    add(0, O_R, 0, 1, 0, 1, ex(0,0,0,0,0,0,2,0,0,4'd1,0,4'd6));
    add(0, O_R, 0, 1, 0, 1, awb);
    add(0, O_R, 5, 0, 0, 1, f1);
    add(0, O_R, 5, 0, 0, 1, dc);
    add(0, O_R, 5, 0, 0, 1, ex(0,0,0,0,0,0,2,0,0,4'd8,0,4'd6));
    add(0, O_R, 5, 0, 0, 1, awb);
    add(0, O_I, 5, 1, 0, 1, f1);
    add(0, O_I, 5, 1, 0, 1, dc);
    add(0, O_I, 5, 1, 0, 1, ex(0,0,0,0,0,0,2,1,0,4'd9,0,4'd7));
    add(0, O_I, 5, 1, 0, 1, awb);
    add(0, O_I, 0, 1, 0, 1, f1);
    add(0, O_I, 0, 1, 0, 1, dc);
    add(0, O_I, 0, 1, 0, 1, ex(0,0,0,0,0,0,2,1,0,4'd0,0,4'd7));
    add(0, O_I, 0, 1, 0, 1, awb);
    // JAL
    add(0, O_JAL, 0, 0, 0, 1, f1);
    add(0, O_JAL, 0, 0, 0, 1, dc);
    add(0, O_JAL, 0, 0, 0, 1, ex(1,0,0,0,0,0,1,2,0,4'd0,0,4'd10));
    add(0, O_JAL, 0, 0, 0, 1, awb);
    // JALR -> JAL -> ALUWB
    add(0, O_JR, 0, 0, 0, 1, f1);
    add(0, O_JR, 0, 0, 0, 1, dc);
    add(0, O_JR, 0, 0, 0, 1, ex(1,0,0,0,0,2,2,1,0,4'd0,0,4'd11));
    add(0, O_JR, 0, 0, 0, 1, ex(1,0,0,0,0,0,1,2,0,4'd0,0,4'd10));
    add(0, O_JR, 0, 0, 0, 1, awb);
    // LUI
    add(0, O_LUI, 0, 0, 0, 1, f1);
    add(0, O_LUI, 0, 0, 0, 1, dc);
    add(0, O_LUI, 0, 0, 0, 1, ex(0,0,0,0,0,0,2,1,4,4'd0,0,4'd12));
    add(0, O_LUI, 0, 0, 0, 1, awb);
    // reset mid-store wait suppresses MEM_WRITE, then back to FETCH
    add(0, O_ST, 0, 0, 0, 1, f1);
    add(0, O_ST, 0, 0, 0, 1, dc);
    add(0, O_ST, 0, 0, 0, 1, ex(0,0,0,0,0,0,2,1,1,4'd0,0,4'd2));
    add(0, O_ST, 0, 0, 0, 0, ex(0,1,1,0,0,0,0,0,0,4'd0,0,4'd5));
    add(1, O_ST, 0, 0, 0, 1, ex(0,1,0,0,0,0,0,0,0,4'd0,0,4'd5));
    add(0, O_ST, 0, 0, 0, 0, f0);
    // unsupported branch funct3 traps
    add(0, O_BR, 4, 0, 1, 1, f1);
    add(0, O_BR, 4, 0, 1, 1, dc);
    add(0, O_BR, 4, 0, 1, 1, ex(0,0,0,0,0,0,2,0,0,4'd1,0,4'd9));
    add(0, O_BR, 4, 0, 1, 1, ex(0,0,0,0,0,0,0,0,0,4'd0,1,4'd13));
    add(1, O_BR, 4, 0, 1, 1, ex(0,0,0,0,0,0,0,0,0,4'd0,1,4'd13));
    add(0, O_BR, 4, 0, 1, 0, f0);

    RESET = 1'b1; op = '0; f3 = '0; f7_5 = 1'b0;
    ZERO = 1'b0; MEM_READY = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f75,
            vecs[i].z, vecs[i].mr);
      check($sformatf("vec[%0d]", i), vecs[i].exp);
      @(negedge CLK);
    end

    // op=0000000: trap with no strobes for 10 cycles, then reset
    drive(0, 7'd0, 0, 0, 1, 1);
    check("ill_fetch", f1);
    @(negedge CLK);
    drive(0, 7'd0, 0, 0, 1, 1);
    check("ill_decode", dc);
    @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      drive(0, 7'd0, 3'(i), i[0], i[1], 1);
      check($sformatf("trap[%0d]", i),
            ex(0,0,0,0,0,0,0,0,0,4'd0,1,4'd13));
      @(negedge CLK);
    end
    drive(1, 7'd0, 0, 0, 1, 1);
    check("trap_rst", ex(0,0,0,0,0,0,0,0,0,4'd0,1,4'd13));
    @(negedge CLK);
    drive(0, 7'd0, 0, 0, 0, 0);
    check("post_rst", f0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
